seg_capture: RTL and testbench

- Receive-side counterpart of the two-digit multiplexed 7-segment drive: samples segment lines `AN` and digit select `CA`, decodes each digit back to a 4-bit value and demultiplexes it by `CA`.
- Sits in loopback and self-check builds next to the FSM display path. It reports recovered digits with a frame-valid pulse, plus error and signal-lost flags.

---
 rtl/seg_capture_if.sv | 46 ++++
 rtl/seg_capture.sv | 183 ++++++++++++++++++
 tb/tb_seg_capture.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_capture_if
// Description : Bundles the multiplexed 7-segment lines sampled by
//               seg_capture and the recovered-digit status it reports.
//               master : drives AN/CA and observes the results (display side
//                        or test harness).
//               slave  : samples AN/CA and drives the results (seg_capture).
//   AN[6:0]     segment lines {A,B,C,D,E,F,G}, active-high
//   CA          digit select, 1 = digit1, 0 = digit0
//   DIGIT0/1    last decoded value for each digit position
//   VALID       one-cycle pulse once both digits have been captured
//   ERR         sticky undecodable-pattern flag
//   LOST        no CA edge seen for the timeout period
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_capture_if;
    logic [6:0] AN;
    logic       CA;
    logic [3:0] DIGIT0;
    logic [3:0] DIGIT1;
    logic       VALID;
    logic       ERR;
    logic       LOST;

    modport master (
        output AN,
        output CA,
        input  DIGIT0,
        input  DIGIT1,
        input  VALID,
        input  ERR,
        input  LOST
    );

    modport slave (
        input  AN,
        input  CA,
        output DIGIT0,
        output DIGIT1,
        output VALID,
        output ERR,
        output LOST
    );
endinterface
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_capture
// Description : Receive side of a two-digit multiplexed 7-segment drive.
//               Synchronises AN/CA, waits for the segment lines to settle
//               after every CA edge, decodes the pattern back to a 4-bit
//               digit and stores it by CA. Reports a frame-valid pulse when
//               both digits have been captured, a sticky decode error and a
//               loss-of-signal flag when CA stops toggling.
// Ports       : CLK  - system clock
//               RST  - synchronous active-high reset
//               bus  - seg_capture_if.slave (AN, CA in; DIGIT0, DIGIT1,
//                      VALID, ERR, LOST out)
// Parameters  : SETTLE  - stable cycles required before sampling (>= 1)
//               TIMEOUT - cycles without a CA edge before LOST is raised
// Revision    : 1.0 - initial release
// ============================================================================
module seg_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 3_000_000
) (
    input  logic         CLK,
    input  logic         RST,
    seg_capture_if.slave bus
);

    localparam logic [31:0] SCNT_LAST  = 32'(SETTLE - 1);
    localparam logic [31:0] TCNT_LIMIT = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Returns {bad, value}; unknown patterns map to 4'hF with bad set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = 5'h00;
            7'h30:   res = 5'h01;
            7'h6D:   res = 5'h02;
            7'h79:   res = 5'h03;
            7'h33:   res = 5'h04;
            7'h5B:   res = 5'h05;
            7'h5F:   res = 5'h06;
            7'h70:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h7B:   res = 5'h09;
            default: res = 5'h1F;
        endcase
        return res;
    endfunction

    // Synchroniser and one-cycle history stages
    logic [6:0] an_m, an_s, an_p;
    logic       ca_m, ca_s, ca_p;

    state_t      state, state_nxt;
    logic [31:0] scnt, scnt_nxt;
    logic [31:0] tcnt, tcnt_inc;
    logic [1:0]  got;
    logic [3:0]  digit0, digit1;
    logic        valid, err, lost;

    logic        ca_edge;
    logic        an_stable;
    logic        timeout;
    logic        wr_en;
    logic [4:0]  dec;

    assign ca_edge   = (ca_s != ca_p);
    assign an_stable = (an_s == an_p);
    assign tcnt_inc  = (tcnt == 32'hFFFF_FFFF) ? tcnt : tcnt + 32'd1;
    // An edge in the same cycle restarts the count, so it overrides timeout.
    assign timeout   = !ca_edge && (tcnt_inc == TCNT_LIMIT);
    assign dec       = decode(an_s);

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        wr_en     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (ca_edge) begin
                    state_nxt = ST_SETTLE;
                    scnt_nxt  = 32'd0;
                end
            end
            ST_SETTLE: begin
                if (ca_edge || !an_stable) begin
                    // New digit slot or moving segments: start the run over.
                    scnt_nxt = 32'd0;
                end else if (scnt == SCNT_LAST) begin
                    // This stable cycle completes SETTLE in a row.
                    wr_en     = 1'b1;
                    state_nxt = ST_HOLD;
                    scnt_nxt  = 32'd0;
                end else begin
                    scnt_nxt = scnt + 32'd1;
                end
            end
            ST_HOLD: begin
                if (ca_edge) begin
                    state_nxt = ST_SETTLE;
                    scnt_nxt  = 32'd0;
                end
            end
            default: begin
                state_nxt = ST_SYNC;
                scnt_nxt  = 32'd0;
            end
        endcase
        if (timeout) begin
            state_nxt = ST_SYNC;
            scnt_nxt  = 32'd0;
            wr_en     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            an_m   <= 7'd0;
            an_s   <= 7'd0;
            an_p   <= 7'd0;
            ca_m   <= 1'b0;
            ca_s   <= 1'b0;
            ca_p   <= 1'b0;
            state  <= ST_SYNC;
            scnt   <= 32'd0;
            tcnt   <= 32'd0;
            got    <= 2'b00;
            digit0 <= 4'd0;
            digit1 <= 4'd0;
            valid  <= 1'b0;
            err    <= 1'b0;
            lost   <= 1'b0;
        end else begin
            an_m  <= bus.AN;
            an_s  <= an_m;
            an_p  <= an_s;
            ca_m  <= bus.CA;
            ca_s  <= ca_m;
            ca_p  <= ca_s;
            state <= state_nxt;
            scnt  <= scnt_nxt;
            tcnt  <= ca_edge ? 32'd0 : tcnt_inc;

            if (ca_edge) begin
                lost <= 1'b0;
            end else if (timeout) begin
                lost <= 1'b1;
            end

            // got reaching 2'b11 is reported one cycle later and then emptied.
            valid <= (got == 2'b11);
            if (timeout || (got == 2'b11)) begin
                got <= 2'b00;
            end else if (wr_en) begin
                got[ca_s] <= 1'b1;
            end

            if (wr_en) begin
                if (ca_s) begin
                    digit1 <= dec[3:0];
                end else begin
                    digit0 <= dec[3:0];
                end
                if (dec[4]) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign bus.DIGIT0 = digit0;
    assign bus.DIGIT1 = digit1;
    assign bus.VALID  = valid;
    assign bus.ERR    = err;
    assign bus.LOST   = lost;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_capture
// Description : Self-checking bench for seg_capture (SETTLE=4, TIMEOUT=64).
//               Directed scenarios followed by randomized digit windows.
//               A reference model derives expected outputs from the recorded
//               pin history: an edge is a CA change seen through the input
//               pipeline, a digit is captured once SETTLE consecutive stable
//               AN samples follow the latest edge, and LOST follows TIMEOUT
//               edge-free cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int HMAX    = 8192;

    logic clk;
    logic rst;

    seg_capture_if bus ();

    seg_capture #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // ---------------- reference model ----------------
    logic       pin_ca [HMAX];
    logic [6:0] pin_an [HMAX];
    int         cyc    = 0;
    int         rst_at = 0;

    logic [3:0] m_d0, m_d1;
    logic       m_valid, m_err, m_lost, m_armed, m_done;
    logic [1:0] m_got;
    int         m_win;
    longint     m_tcnt;

    function automatic logic caf(input int k);
        return (k <= rst_at) ? 1'b0 : pin_ca[k];
    endfunction

    function automatic logic [6:0] anf(input int k);
        return (k <= rst_at) ? 7'd0 : pin_an[k];
    endfunction

    always @(posedge clk) begin
        logic       ok;
        logic       sel;
        logic [3:0] val;
        cyc++;
        pin_ca[cyc] = bus.CA;
        pin_an[cyc] = bus.AN;
        if (rst) begin
            rst_at  = cyc;
            m_d0    = 4'd0;
            m_d1    = 4'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_lost  = 1'b0;
            m_armed = 1'b0;
            m_done  = 1'b0;
            m_got   = 2'b00;
            m_win   = 0;
            m_tcnt  = 0;
        end else begin
            m_valid = (m_got == 2'b11);
            if (m_valid) m_got = 2'b00;
            if (caf(cyc - 2) != caf(cyc - 3)) begin
                m_armed = 1'b1;
                m_done  = 1'b0;
                m_win   = cyc;
                m_lost  = 1'b0;
                m_tcnt  = 0;
            end else begin
                m_tcnt++;
                if (m_tcnt == TIMEOUT) begin
                    m_lost  = 1'b1;
                    m_armed = 1'b0;
                    m_got   = 2'b00;
                end else if (m_armed && !m_done && (cyc - m_win >= SETTLE)) begin
                    ok = 1'b1;
                    for (int k = cyc - SETTLE + 1; k <= cyc; k++)
                        if (anf(k - 2) != anf(k - 3)) ok = 1'b0;
                    if (ok) begin
                        m_done = 1'b1;
                        sel    = caf(cyc - 2);
                        val    = 4'hF;
                        for (int i = 0; i < 10; i++)
                            if (pat_tbl[i] == anf(cyc - 2)) val = 4'(i);
                        if (val == 4'hF) m_err = 1'b1;
                        if (sel) m_d1 = val;
                        else     m_d0 = val;
                        m_got[sel] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("DIGIT0", 32'(bus.DIGIT0), 32'(m_d0));
        chk("DIGIT1", 32'(bus.DIGIT1), 32'(m_d1));
        chk("VALID",  32'(bus.VALID),  32'(m_valid));
        chk("ERR",    32'(bus.ERR),    32'(m_err));
        chk("LOST",   32'(bus.LOST),   32'(m_lost));
    endtask

    // Apply pin levels, then check every following cycle at the falling edge.
    task automatic drive(input logic ca, input logic [6:0] an, input int n);
        bus.CA = ca;
        bus.AN = an;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
            if (bus.VALID) vcount++;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         v0;
        logic       cur;
        logic [6:0] pat;
        int         len;
        int         r;

        // Reset with random pins
        rst = 1'b1;
        drive(1'($urandom), 7'($urandom), 3);
        chk("reset_digit0", 32'(bus.DIGIT0), 32'd0);
        chk("reset_digit1", 32'(bus.DIGIT1), 32'd0);
        chk("reset_flags",  {29'd0, bus.VALID, bus.ERR, bus.LOST}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 7'h00, 8);

        // Normal frames; measure first VALID relative to the CA fall
        drive(1'b1, 7'h7E, 20);
        lat = 0;
        bus.CA = 1'b0;
        bus.AN = 7'h30;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 7'h30, 1);
            if (bus.VALID && lat == 0) lat = i;
        end
        chk("first_valid_latency", 32'(lat), 32'(SETTLE + 4));
        v0 = vcount;
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 7'h7E, 20);
            drive(1'b0, 7'h30, 20);
        end
        chk("frames_valid_count", 32'(vcount - v0), 32'd2);
        chk("frames_digit1", 32'(bus.DIGIT1), 32'd0);
        chk("frames_digit0", 32'(bus.DIGIT0), 32'd1);

        // Glitch filtering inside a CA=1 window
        for (int g = 0; g < 5; g++) begin
            drive(1'b1, 7'h00, 2);
            drive(1'b1, 7'h79, 2);
        end
        drive(1'b1, 7'h79, 20);
        chk("glitch_digit1", 32'(bus.DIGIT1), 32'd3);
        chk("glitch_err",    32'(bus.ERR),    32'd0);
        drive(1'b0, 7'h30, 20);

        // Invalid pattern, ERR sticky through valid frames
        drive(1'b1, 7'h7E, 20);
        drive(1'b0, 7'h00, 20);
        chk("invalid_digit0", 32'(bus.DIGIT0), 32'hF);
        chk("invalid_err",    32'(bus.ERR),    32'd1);
        drive(1'b1, 7'h7E, 20);
        drive(1'b0, 7'h30, 20);
        chk("err_sticky", 32'(bus.ERR), 32'd1);

        // Loss of signal
        drive(1'b0, 7'h30, 70);
        chk("lost_set",     32'(bus.LOST),   32'd1);
        chk("lost_digit0",  32'(bus.DIGIT0), 32'd1);
        chk("lost_digit1",  32'(bus.DIGIT1), 32'd0);
        v0 = vcount;
        drive(1'b1, 7'h79, 20);
        chk("lost_cleared", 32'(bus.LOST), 32'd0);
        chk("lost_no_early_valid", 32'(vcount - v0), 32'd0);
        drive(1'b0, 7'h5B, 20);
        chk("lost_valid_after_two", 32'(vcount - v0), 32'd1);
        chk("lost_new_digit0", 32'(bus.DIGIT0), 32'd5);

        // Reset two cycles into SETTLE
        drive(1'b1, 7'h7E, 4);
        rst = 1'b1;
        drive(1'b1, 7'h7E, 2);
        rst = 1'b0;
        v0 = vcount;
        drive(1'b1, 7'h7E, 20);
        chk("rst_settle_no_valid", 32'(vcount - v0), 32'd0);
        chk("rst_settle_outputs",
            {21'd0, bus.DIGIT0, bus.DIGIT1, bus.VALID, bus.ERR, bus.LOST}, 32'd0);

        // Randomized windows
        cur = 1'b1;
        for (int w = 0; w < 40; w++) begin
            r   = int'($urandom_range(0, 19));
            len = int'($urandom_range(3, 25));
            pat = pat_tbl[$urandom_range(0, 9)];
            if (r != 4) cur = ~cur;
            if (r == 0) pat = 7'($urandom);
            if (r == 1) drive(cur, 7'($urandom), 2);
            if (r == 2) len = int'($urandom_range(65, 80));
            if (r == 3) begin
                rst = 1'b1;
                drive(cur, pat, 2);
                rst = 1'b0;
            end
            drive(cur, pat, len);
        end
        drive(cur, 7'h7E, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
